// File: rtl/input_memory_responder_pkg.sv
// Shared constants for the input memory read handshake: a read is accepted when
// req and ack are high in the same cycle, and data returns with a DataValid pulse.
package input_memory_responder_pkg;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 4;
  localparam int READ_COUNT_WIDTH = 16;

  // Host writes own the array in any cycle they are strobed; reset blocks reads.
  function automatic logic read_accept(input logic req, input logic write_en,
                                       input logic rst_n);
    return req & ~write_en & rst_n;
  endfunction

  function automatic int clamp_latency(input int lat);
    if (lat < READ_LATENCY_MIN) return READ_LATENCY_MIN;
    if (lat > READ_LATENCY_MAX) return READ_LATENCY_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/input_memory_responder_latency_pipe.sv
// Valid/data delay line: an entry pushed in cycle t appears on the output in cycle t+DEPTH.
module latency_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];

  // Invalid slots carry zero data so the output is already zero whenever valid is low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_valid ? i_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/input_memory_responder.sv
// Host-written word array serving fixed-latency user reads through a valid/data delay line.
module input_memory_responder
  import input_memory_responder_pkg::*;
#(
  parameter int INMEM_BYTE_WIDTH    = 1,
  parameter int INMEM_ADDRESS_WIDTH = 6,
  parameter int READ_LATENCY        = 2
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            hostWriteEn,
  input  logic [INMEM_ADDRESS_WIDTH-1:0]  hostWriteAdd,
  input  logic [INMEM_BYTE_WIDTH*8-1:0]   hostWriteData,
  input  logic                            inputMemoryReadReq,
  output logic                            inputMemoryReadAck,
  input  logic [INMEM_ADDRESS_WIDTH-1:0]  inputMemoryReadAdd,
  output logic                            inputMemoryReadDataValid,
  output logic [INMEM_BYTE_WIDTH*8-1:0]   inputMemoryReadData,
  output logic [15:0]                     readCount
);

  localparam int DATA_W     = INMEM_BYTE_WIDTH * 8;
  localparam int MEM_DEPTH  = 2 ** INMEM_ADDRESS_WIDTH;
  localparam int PIPE_DEPTH = clamp_latency(READ_LATENCY);

  logic [DATA_W-1:0]           r_mem [MEM_DEPTH];
  logic [READ_COUNT_WIDTH-1:0] r_read_count;
  logic                        w_accept;
  logic [DATA_W-1:0]           w_rd_data;

  // Storage is deliberately outside reset: the host may preload it while reset is held.
  always_ff @(posedge clk) begin
    if (hostWriteEn) r_mem[hostWriteAdd] <= hostWriteData;
  end

  // A write never coexists with an accept, so sampling the array now equals its
  // contents at the end of the accept cycle; later writes cannot reach the pipe.
  assign w_accept  = read_accept(inputMemoryReadReq, hostWriteEn, reset_n);
  assign w_rd_data = w_accept ? r_mem[inputMemoryReadAdd] : '0;

  always_ff @(posedge clk) begin
    if (!reset_n)      r_read_count <= '0;
    else if (w_accept) r_read_count <= r_read_count + 1'b1;
  end

  latency_pipe #(
    .DEPTH (PIPE_DEPTH),
    .WIDTH (DATA_W)
  ) u_latency_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .i_valid (w_accept),
    .i_data  (w_rd_data),
    .o_valid (inputMemoryReadDataValid),
    .o_data  (inputMemoryReadData)
  );

  assign inputMemoryReadAck = w_accept;
  assign readCount          = r_read_count;

endmodule

// File: tb/tb_input_memory_responder.sv
// Directed bench for input_memory_responder: default build plus a READ_LATENCY=4 build on shared stimulus.
module tb_input_memory_responder;

  logic       clk;
  logic       reset_n;
  logic       host_we;
  logic [5:0] host_add;
  logic [7:0] host_data;
  logic       rd_req;
  logic [5:0] rd_add;
  logic       ack2, dv2, ack4, dv4;
  logic [7:0] data2, data4;
  logic [15:0] cnt2, cnt4;

  int checks = 0;
  int errors = 0;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  input_memory_responder dut (
    .clk(clk), .reset_n(reset_n),
    .hostWriteEn(host_we), .hostWriteAdd(host_add), .hostWriteData(host_data),
    .inputMemoryReadReq(rd_req), .inputMemoryReadAck(ack2), .inputMemoryReadAdd(rd_add),
    .inputMemoryReadDataValid(dv2), .inputMemoryReadData(data2), .readCount(cnt2)
  );

  input_memory_responder #(.READ_LATENCY(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .hostWriteEn(host_we), .hostWriteAdd(host_add), .hostWriteData(host_data),
    .inputMemoryReadReq(rd_req), .inputMemoryReadAck(ack4), .inputMemoryReadAdd(rd_add),
    .inputMemoryReadDataValid(dv4), .inputMemoryReadData(data4), .readCount(cnt4)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [5:0] a, input logic [7:0] d);
    host_we = 1'b1; host_add = a; host_data = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; host_we = 1'b0; host_add = '0; host_data = '0;
    rd_req = 1'b0; rd_add = '0;

    // reset: ack blocked even with req high; host write allowed during reset
    tick();
    rd_req = 1'b1;
    #1;
    chk("rst_ack", 32'(ack2), 32'd0);
    tick();
    rd_req = 1'b0;
    host_write(6'd0, 8'h11);
    reset_n = 1'b1;
    chk("rst_dv", 32'(dv2), 32'd0);
    chk("rst_data", 32'(data2), 32'd0);
    chk("rst_cnt", 32'(cnt2), 32'd0);
    host_write(6'd1, 8'h22);

    // single read of addr 0
    rd_req = 1'b1; rd_add = 6'd0;
    #1;
    chk("t1_ack", 32'(ack2), 32'd1);
    tick();
    rd_req = 1'b0;
    chk("t1_dv_p1", 32'(dv2), 32'd0);
    chk("t1_data_p1", 32'(data2), 32'd0);
    tick();
    chk("t1_dv_p2", 32'(dv2), 32'd1);
    chk("t1_data_p2", 32'(data2), 32'h11);
    chk("t1_cnt", 32'(cnt2), 32'd1);
    chk("t1_l4_dv_p2", 32'(dv4), 32'd0);
    tick();
    chk("t1_dv_p3", 32'(dv2), 32'd0);
    chk("t1_data_p3", 32'(data2), 32'd0);
    chk("t1_l4_dv_p3", 32'(dv4), 32'd0);
    tick();
    chk("t1_l4_dv_p4", 32'(dv4), 32'd1);
    chk("t1_l4_data_p4", 32'(data4), 32'h11);
    tick();
    chk("t1_l4_dv_p5", 32'(dv4), 32'd0);

    // back-to-back reads of A0..A3
    for (int i = 0; i < 4; i++) host_write(6'(i), 8'(8'hA0 + i));
    for (int i = 0; i < 7; i++) begin
      rd_req = (i < 4);
      rd_add = 6'(i);
      if (i >= 2) begin
        chk("t2_dv", 32'(dv2), (i - 2 < 4) ? 32'd1 : 32'd0);
        chk("t2_data", 32'(data2), (i - 2 < 4) ? 32'(8'hA0 + i - 2) : 32'd0);
      end
      tick();
    end
    chk("t2_cnt", 32'(cnt2), 32'd5);

    // host write collides with read request
    rd_req = 1'b1; rd_add = 6'd5;
    host_we = 1'b1; host_add = 6'd5; host_data = 8'h5A;
    #1;
    chk("t3_ack_blocked", 32'(ack2), 32'd0);
    tick();
    host_we = 1'b0;
    #1;
    chk("t3_ack_next", 32'(ack2), 32'd1);
    tick();
    rd_req = 1'b0;
    chk("t3_dv_early", 32'(dv2), 32'd0);
    tick();
    chk("t3_dv", 32'(dv2), 32'd1);
    chk("t3_data", 32'(data2), 32'h5A);
    tick();
    chk("t3_cnt", 32'(cnt2), 32'd6);

    // later write does not disturb an in-flight read
    host_write(6'd7, 8'h01);
    rd_req = 1'b1; rd_add = 6'd7;
    tick();
    rd_req = 1'b0;
    host_write(6'd7, 8'hFF);
    chk("t4_dv", 32'(dv2), 32'd1);
    chk("t4_data", 32'(data2), 32'h01);
    tick();
    chk("t4_cnt", 32'(cnt2), 32'd7);

    // reset with reads in flight
    rd_req = 1'b1; rd_add = 6'd0;
    tick();
    rd_add = 6'd1;
    tick();
    rd_req = 1'b0; reset_n = 1'b0;
    chk("t5_dv_pre", 32'(dv2), 32'd1);
    chk("t5_data_pre", 32'(data2), 32'hA0);
    chk("t5_cnt_pre", 32'(cnt2), 32'd9);
    tick();
    reset_n = 1'b1;
    chk("t5_cnt", 32'(cnt2), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t5_dv", 32'(dv2), 32'd0);
      chk("t5_data", 32'(data2), 32'd0);
      chk("t5_l4_dv", 32'(dv4), 32'd0);
      chk("t5_l4_data", 32'(data4), 32'd0);
      tick();
    end
    chk("t5_cnt_after", 32'(cnt2), 32'd0);

    // counter wrap: 65537 accepts
    rd_req = 1'b1; rd_add = 6'd2;
    for (int n = 0; n < 65537; n++) tick();
    rd_req = 1'b0;
    chk("t6_cnt_wrap", 32'(cnt2), 32'd1);
    chk("t6_l4_cnt_wrap", 32'(cnt4), 32'd1);
    tick();
    chk("t6_cnt_hold", 32'(cnt2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_memory_responder.md
INPUT_MEMORY_RESPONDER -- requirements
Module: input_memory_responder

Interface
REQ-001 SHALL have parameter INMEM_BYTE_WIDTH, default 1; byte width of one user word (power of 2 >= 1).
REQ-002 SHALL have parameter INMEM_ADDRESS_WIDTH, default 6; user word address width; depth = 2**INMEM_ADDRESS_WIDTH.
REQ-003 SHALL have parameter READ_LATENCY, default 2; accept-to-DataValid cycles, legal 1..4.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-006 SHALL have port hostWriteEn  in  1  host byte-word write strobe.
REQ-007 SHALL have port hostWriteAdd  in  INMEM_ADDRESS_WIDTH  host write address.
REQ-008 SHALL have port hostWriteData  in  INMEM_BYTE_WIDTH*8  host write data.
REQ-009 SHALL have port inputMemoryReadReq  in  1  user read request.
REQ-010 SHALL have port inputMemoryReadAck  out  1  accept; request accepted when Req and Ack high in the same cycle.
REQ-011 SHALL have port inputMemoryReadAdd  in  INMEM_ADDRESS_WIDTH  read address, sampled in the accept cycle.
REQ-012 SHALL have port inputMemoryReadDataValid  out  1  one-cycle pulse per accepted read.
REQ-013 SHALL have port inputMemoryReadData  out  INMEM_BYTE_WIDTH*8  read data, valid only with DataValid.
REQ-014 SHALL have port readCount  out  16  number of accepted reads since reset, wraps.

Function
REQ-015 SHALL hold the storage array (depth x word) written only by the host port; contents not cleared by reset.
REQ-016 SHALL assert inputMemoryReadAck combinationally = inputMemoryReadReq AND NOT hostWriteEn AND reset_n high.
REQ-017 SHALL give host writes priority: in a cycle with hostWriteEn high no read is accepted; the write completes that cycle.
REQ-018 SHALL pulse inputMemoryReadDataValid exactly READ_LATENCY cycles after each accept cycle, in accept order.
REQ-019 SHALL sustain one accept per cycle (back-to-back accepts give back-to-back DataValid pulses); no backpressure on return data.
REQ-020 SHALL return array contents as of the end of the accept cycle; a host write to the same address in a later cycle does not alter an in-flight read.
REQ-021 SHALL drive inputMemoryReadData to zero in every cycle DataValid is low.
REQ-022 SHALL carry the pipeline as a READ_LATENCY-deep valid/data shift register; no state machine beyond it.
REQ-023 SHALL increment readCount by 1 per accept, wrapping 16'hFFFF -> 0.
REQ-024 SHALL ignore inputMemoryReadAdd when Req is low; no address range check (full width always in range).
REQ-025 SHALL, on reset mid-operation, discard all in-flight reads: no DataValid pulse appears for reads accepted before reset.

Reset
REQ-026 SHALL, while reset_n low at a clock edge, clear pipeline valids, inputMemoryReadDataValid=0, inputMemoryReadData=0, readCount=0.
REQ-027 SHALL hold inputMemoryReadAck=0 while reset_n is low; host writes still permitted during reset.

Structure
REQ-028 SHALL place no shared typedefs; the handshake convention (req/ack same-cycle accept, DataValid return) is defined in the team's shared interface package, and READ_LATENCY bounds as constants there.
REQ-029 SHALL be a single module plus one sub-module, latency_pipe (parameterised valid/data delay line).

Verification
REQ-030 SHALL cover: host writes 0x11,0x22 to addr 0,1; Req addr 0 one cycle -> Ack same cycle, DataValid+0x11 at +2 cycles, readCount=1.
REQ-031 SHALL cover: Req held 4 cycles, addr 0..3 holding 0xA0..0xA3 -> four consecutive DataValid pulses 0xA0,0xA1,0xA2,0xA3.
REQ-032 SHALL cover: Req and hostWriteEn (addr 5, 0x5A) same cycle -> Ack=0 that cycle, Ack=1 next cycle, read of addr 5 returns 0x5A.
REQ-033 SHALL cover: accept read addr 7 (holds 0x01), host writes 0xFF to addr 7 next cycle -> returned data 0x01.
REQ-034 SHALL cover: two reads in flight, reset_n low one cycle -> no DataValid pulses, readCount=0, data output 0.
REQ-035 SHALL cover: 65537 accepts -> readCount=1; READ_LATENCY=4 build returns first DataValid at +4 cycles.
